// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared constants, load-type encoding and misalignment helper
// for the MEM/WB pipeline stage.
//   DATA_W          datapath width (only 32 supported)
//   load_type_e     load size/sign codes; unlisted codes behave as LW
//   is_misaligned() raw alignment check of a load given its type and addr[1:0]
package mem_wb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } load_type_e;

  // Alignment check only; the caller qualifies it with valid and MemtoReg.
  // Reserved codes fall into the default arm and are checked as words.
  function automatic logic is_misaligned(input logic [2:0] load_type,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (load_type)
      LT_LH, LT_LHU: mis = addr_lo[0];
      LT_LB, LT_LBU: mis = 1'b0;
      default:       mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// load_extract: combinational load-data lane select and extension.
//   read_data  in   DATA_W  word from data memory
//   addr_lo    in   2       byte lane (little-endian, lane 0 = bits [7:0])
//   load_type  in   3       load size/sign code
//   ext_data   out  DATA_W  selected and extended load data
//   misalign   out  1       raw misalignment flag for this load type/lane
module load_extract
  import mem_wb_pkg::*;
(
  input  logic [DATA_W-1:0] read_data,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] ext_data,
  output logic              misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for byte and halfword loads.
  always_comb begin
    byte_s = read_data[7:0];
    case (addr_lo)
      2'd0:    byte_s = read_data[7:0];
      2'd1:    byte_s = read_data[15:8];
      2'd2:    byte_s = read_data[23:16];
      2'd3:    byte_s = read_data[31:24];
      default: byte_s = read_data[7:0];
    endcase
    // Odd halfword addresses are flagged misaligned; bit 1 alone picks the half.
    if (addr_lo[1]) begin
      half_s = read_data[31:16];
    end else begin
      half_s = read_data[15:0];
    end
  end

  // Extension according to load type; reserved codes return the full word.
  always_comb begin
    ext_data = read_data;
    case (load_type)
      LT_LB:   ext_data = {{24{byte_s[7]}}, byte_s};
      LT_LBU:  ext_data = {24'd0, byte_s};
      LT_LH:   ext_data = {{16{half_s[15]}}, half_s};
      LT_LHU:  ext_data = {16'd0, half_s};
      default: ext_data = read_data;
    endcase
    misalign = is_misaligned(load_type, addr_lo);
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extraction, ALU/memory
// result select and a sticky first-fault misaligned-load exception record.
// Optional build macro MEM_WB_RETIRE_CNT_EN adds a 32-bit Retired_Count output
// counting captured valid, non-faulting instructions.
// Ports:
//   Clk, Reset_n                      clock, async active-low reset
//   Valid_MEM .. Load_Type_MEM        MEM-stage bundle
//   Stall_WB / Flush_WB               hold / bubble (flush wins)
//   Exc_Ack                           clears the pending exception
//   Write_Data_WB, Write_Register_WB,
//   RegWrite_WB, Valid_WB             registered write-back bundle
//   Exc_Pending_WB, Exc_Addr_WB       sticky exception flag and first address
//   Retired_Count                     (macro only) retired instruction count
module mem_wb_stage #(
  parameter int DATA_W     = mem_wb_pkg::DATA_W,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Valid_MEM,
  input  logic [DATA_W-1:0]     Read_Data_MEM,
  input  logic [DATA_W-1:0]     ALU_Result_MEM,
  input  logic [REG_ADDR_W-1:0] Write_Register_MEM,
  input  logic                  RegWrite_MEM,
  input  logic                  MemtoReg_MEM,
  input  logic [2:0]            Load_Type_MEM,
  input  logic                  Stall_WB,
  input  logic                  Flush_WB,
  input  logic                  Exc_Ack,
`ifdef MEM_WB_RETIRE_CNT_EN
  output logic [31:0]           Retired_Count,
`endif
  output logic [DATA_W-1:0]     Write_Data_WB,
  output logic [REG_ADDR_W-1:0] Write_Register_WB,
  output logic                  RegWrite_WB,
  output logic                  Valid_WB,
  output logic                  Exc_Pending_WB,
  output logic [DATA_W-1:0]     Exc_Addr_WB
);

  import mem_wb_pkg::*;

  logic [DATA_W-1:0]     ext_data_s;
  logic                  ext_mis_s;
  logic                  capture_s;
  logic                  mis_s;

  logic [DATA_W-1:0]     write_data_d, write_data_q;
  logic [REG_ADDR_W-1:0] write_reg_d, write_reg_q;
  logic                  regwrite_d, regwrite_q;
  logic                  valid_d, valid_q;
  logic                  exc_pending_d, exc_pending_q;
  logic [DATA_W-1:0]     exc_addr_d, exc_addr_q;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0]           retired_d, retired_q;
`endif

  load_extract u_load_extract (
    .read_data (Read_Data_MEM),
    .addr_lo   (ALU_Result_MEM[1:0]),
    .load_type (Load_Type_MEM),
    .ext_data  (ext_data_s),
    .misalign  (ext_mis_s)
  );

  assign capture_s = !Flush_WB && !Stall_WB;
  assign mis_s     = Valid_MEM && MemtoReg_MEM && ext_mis_s;

  // Next-state of the write-back bundle: flush > stall > capture.
  always_comb begin
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    regwrite_d   = regwrite_q;
    valid_d      = valid_q;
    if (Flush_WB) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (Stall_WB) begin
      valid_d    = valid_q;
      regwrite_d = regwrite_q;
    end else begin
      write_reg_d = Write_Register_MEM;
      valid_d     = Valid_MEM;
      // Writes to $zero, bubbles and faulting loads never reach the file.
      regwrite_d  = RegWrite_MEM && Valid_MEM && !mis_s &&
                    (Write_Register_MEM != {REG_ADDR_W{1'b0}});
      if (mis_s) begin
        write_data_d = {DATA_W{1'b0}};
      end else if (MemtoReg_MEM) begin
        write_data_d = ext_data_s;
      end else begin
        write_data_d = ALU_Result_MEM;
      end
    end
  end

  // Next-state of the exception record; a new fault beats a same-cycle ack.
  always_comb begin
    exc_pending_d = exc_pending_q;
    exc_addr_d    = exc_addr_q;
    if (capture_s && mis_s) begin
      exc_pending_d = 1'b1;
      // Address is only replaced if the record is free or being acked now.
      if (!exc_pending_q || Exc_Ack) begin
        exc_addr_d = ALU_Result_MEM;
      end else begin
        exc_addr_d = exc_addr_q;
      end
    end else if (Exc_Ack) begin
      exc_pending_d = 1'b0;
    end else begin
      exc_pending_d = exc_pending_q;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  // Retired-instruction counter; wraps naturally at 32 bits.
  always_comb begin
    if (capture_s && Valid_MEM && !mis_s) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign Retired_Count = retired_q;
`endif

  // Write-back and exception state registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      write_data_q  <= {DATA_W{1'b0}};
      write_reg_q   <= {REG_ADDR_W{1'b0}};
      regwrite_q    <= 1'b0;
      valid_q       <= 1'b0;
      exc_pending_q <= 1'b0;
      exc_addr_q    <= {DATA_W{1'b0}};
    end else begin
      write_data_q  <= write_data_d;
      write_reg_q   <= write_reg_d;
      regwrite_q    <= regwrite_d;
      valid_q       <= valid_d;
      exc_pending_q <= exc_pending_d;
      exc_addr_q    <= exc_addr_d;
    end
  end

  assign Write_Data_WB     = write_data_q;
  assign Write_Register_WB = write_reg_q;
  assign RegWrite_WB       = regwrite_q;
  assign Valid_WB          = valid_q;
  assign Exc_Pending_WB    = exc_pending_q;
  assign Exc_Addr_WB       = exc_addr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
// Expected values are hand-computed constants; the counter checks are
// compiled in only when MEM_WB_RETIRE_CNT_EN is defined.
module tb_mem_wb_stage;

  logic        Clk;
  logic        Reset_n;
  logic        Valid_MEM;
  logic [31:0] Read_Data_MEM;
  logic [31:0] ALU_Result_MEM;
  logic [4:0]  Write_Register_MEM;
  logic        RegWrite_MEM;
  logic        MemtoReg_MEM;
  logic [2:0]  Load_Type_MEM;
  logic        Stall_WB;
  logic        Flush_WB;
  logic        Exc_Ack;
  logic [31:0] Write_Data_WB;
  logic [4:0]  Write_Register_WB;
  logic        RegWrite_WB;
  logic        Valid_WB;
  logic        Exc_Pending_WB;
  logic [31:0] Exc_Addr_WB;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] Retired_Count;
`endif

  int total = 0;
  int bad   = 0;

  mem_wb_stage dut (
    .Clk                (Clk),
    .Reset_n            (Reset_n),
    .Valid_MEM          (Valid_MEM),
    .Read_Data_MEM      (Read_Data_MEM),
    .ALU_Result_MEM     (ALU_Result_MEM),
    .Write_Register_MEM (Write_Register_MEM),
    .RegWrite_MEM       (RegWrite_MEM),
    .MemtoReg_MEM       (MemtoReg_MEM),
    .Load_Type_MEM      (Load_Type_MEM),
    .Stall_WB           (Stall_WB),
    .Flush_WB           (Flush_WB),
    .Exc_Ack            (Exc_Ack),
`ifdef MEM_WB_RETIRE_CNT_EN
    .Retired_Count      (Retired_Count),
`endif
    .Write_Data_WB      (Write_Data_WB),
    .Write_Register_WB  (Write_Register_WB),
    .RegWrite_WB        (RegWrite_WB),
    .Valid_WB           (Valid_WB),
    .Exc_Pending_WB     (Exc_Pending_WB),
    .Exc_Addr_WB        (Exc_Addr_WB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_alu(input logic [31:0] alu, input logic [4:0] rd);
    Valid_MEM          = 1'b1;
    MemtoReg_MEM       = 1'b0;
    RegWrite_MEM       = 1'b1;
    ALU_Result_MEM     = alu;
    Write_Register_MEM = rd;
    Load_Type_MEM      = 3'd0;
  endtask

  task automatic set_load(input logic [31:0] rdata, input logic [31:0] addr,
                          input logic [2:0] lt, input logic [4:0] rd);
    Valid_MEM          = 1'b1;
    MemtoReg_MEM       = 1'b1;
    RegWrite_MEM       = 1'b1;
    Read_Data_MEM      = rdata;
    ALU_Result_MEM     = addr;
    Write_Register_MEM = rd;
    Load_Type_MEM      = lt;
  endtask

  initial begin
    // Reset asserted before the first clock edge, inputs arbitrary.
    Reset_n = 1'b1;
    Stall_WB = 1'b0; Flush_WB = 1'b0; Exc_Ack = 1'b0;
    set_load(32'hFFFF_FFFF, 32'h0000_0023, 3'd0, 5'd9);
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_data",  Write_Data_WB, 32'h0);
    chk("rst_reg",   {27'd0, Write_Register_WB}, 32'h0);
    chk("rst_rw",    {31'd0, RegWrite_WB}, 32'h0);
    chk("rst_valid", {31'd0, Valid_WB}, 32'h0);
    chk("rst_pend",  {31'd0, Exc_Pending_WB}, 32'h0);
    chk("rst_addr",  Exc_Addr_WB, 32'h0);
`ifdef MEM_WB_RETIRE_CNT_EN
    chk("rst_cnt",   Retired_Count, 32'h0);
`endif
    tick(); tick();
    chk("rst_hold_valid", {31'd0, Valid_WB}, 32'h0);
    chk("rst_hold_pend",  {31'd0, Exc_Pending_WB}, 32'h0);
    Reset_n = 1'b1;

    // LB, lane 1, sign-extended.
    set_load(32'h12F4_80AB, 32'h0000_0011, 3'd3, 5'd7);
    tick();
    chk("lb_data",  Write_Data_WB, 32'hFFFF_FF80);
    chk("lb_reg",   {27'd0, Write_Register_WB}, 32'd7);
    chk("lb_rw",    {31'd0, RegWrite_WB}, 32'd1);
    chk("lb_valid", {31'd0, Valid_WB}, 32'd1);

    // LHU / LH, lane 2.
    set_load(32'h8001_0000, 32'h0000_0012, 3'd2, 5'd3);
    tick();
    chk("lhu_data", Write_Data_WB, 32'h0000_8001);
    set_load(32'h8001_0000, 32'h0000_0012, 3'd1, 5'd3);
    tick();
    chk("lh_data",  Write_Data_WB, 32'hFFFF_8001);

    // LBU, lane 3.
    set_load(32'h9AF4_80AB, 32'h0000_0013, 3'd4, 5'd4);
    tick();
    chk("lbu_data", Write_Data_WB, 32'h0000_009A);

    // Reserved type behaves as LW (aligned).
    set_load(32'hCAFE_F00D, 32'h0000_0040, 3'd7, 5'd4);
    tick();
    chk("rsv_data", Write_Data_WB, 32'hCAFE_F00D);
    chk("rsv_pend", {31'd0, Exc_Pending_WB}, 32'd0);

    // Misaligned LW at 0x22: first fault.
    set_load(32'h1234_5678, 32'h0000_0022, 3'd0, 5'd5);
    tick();
    chk("mis_rw",    {31'd0, RegWrite_WB}, 32'd0);
    chk("mis_data",  Write_Data_WB, 32'h0);
    chk("mis_pend",  {31'd0, Exc_Pending_WB}, 32'd1);
    chk("mis_addr",  Exc_Addr_WB, 32'h0000_0022);
    chk("mis_valid", {31'd0, Valid_WB}, 32'd1);

    // Second fault keeps the first address.
    set_load(32'h1234_5678, 32'h0000_0033, 3'd0, 5'd5);
    tick();
    chk("ff_addr", Exc_Addr_WB, 32'h0000_0022);
    chk("ff_pend", {31'd0, Exc_Pending_WB}, 32'd1);

    // Ack together with a new misaligned LH: set wins, new address loaded.
    set_load(32'h1234_5678, 32'h0000_0041, 3'd1, 5'd5);
    Exc_Ack = 1'b1;
    tick();
    chk("ackset_pend", {31'd0, Exc_Pending_WB}, 32'd1);
    chk("ackset_addr", Exc_Addr_WB, 32'h0000_0041);

    // Ack alone clears; ALU result captured.
    set_alu(32'hDEAD_BEEF, 5'd9);
    tick();
    Exc_Ack = 1'b0;
    chk("ack_pend", {31'd0, Exc_Pending_WB}, 32'd0);
    chk("ack_addr", Exc_Addr_WB, 32'h0000_0041);
    chk("alu_data", Write_Data_WB, 32'hDEAD_BEEF);
    chk("alu_rw",   {31'd0, RegWrite_WB}, 32'd1);

    // Stall for 3 cycles while inputs change, including a misaligned load.
    Stall_WB = 1'b1;
    set_alu(32'h1111_1111, 5'd1);
    tick();
    chk("stall1_data", Write_Data_WB, 32'hDEAD_BEEF);
    set_load(32'h0, 32'h0000_0023, 3'd0, 5'd2);
    tick();
    chk("stall2_data", Write_Data_WB, 32'hDEAD_BEEF);
    chk("stall2_pend", {31'd0, Exc_Pending_WB}, 32'd0);
    set_alu(32'h3333_3333, 5'd3);
    tick();
    chk("stall3_data", Write_Data_WB, 32'hDEAD_BEEF);
    chk("stall3_reg",  {27'd0, Write_Register_WB}, 32'd9);
    chk("stall3_rw",   {31'd0, RegWrite_WB}, 32'd1);

    // Flush with stall: bubble, data held.
    Flush_WB = 1'b1;
    tick();
    Flush_WB = 1'b0;
    Stall_WB = 1'b0;
    chk("flush_valid", {31'd0, Valid_WB}, 32'd0);
    chk("flush_rw",    {31'd0, RegWrite_WB}, 32'd0);
    chk("flush_data",  Write_Data_WB, 32'hDEAD_BEEF);

    // Write to $zero.
    set_alu(32'h0000_0055, 5'd0);
    tick();
    chk("zero_rw",   {31'd0, RegWrite_WB}, 32'd0);
    chk("zero_data", Write_Data_WB, 32'h0000_0055);

    // Invalid slot.
    set_alu(32'h0000_0066, 5'd6);
    Valid_MEM = 1'b0;
    tick();
    chk("inv_rw",    {31'd0, RegWrite_WB}, 32'd0);
    chk("inv_valid", {31'd0, Valid_WB}, 32'd0);

    // Reset asserted mid-exception clears immediately.
    set_load(32'h0, 32'h0000_0002, 3'd0, 5'd5);
    tick();
    chk("pre_rst_pend", {31'd0, Exc_Pending_WB}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_pend", {31'd0, Exc_Pending_WB}, 32'd0);
    chk("mid_rst_addr", Exc_Addr_WB, 32'h0);
    chk("mid_rst_valid", {31'd0, Valid_WB}, 32'd0);
    tick();
    Reset_n = 1'b1;

    // Counter sequence: 5 valid captures (1 misaligned) plus 1 stall cycle.
    set_alu(32'h0000_0100, 5'd5);
    tick();
    tick();
    Stall_WB = 1'b1;
    tick();
    Stall_WB = 1'b0;
    set_load(32'h0, 32'h0000_0002, 3'd0, 5'd5);
    tick();
    set_alu(32'h0000_0200, 5'd6);
    tick();
    tick();
    chk("seq_data", Write_Data_WB, 32'h0000_0200);
`ifdef MEM_WB_RETIRE_CNT_EN
    chk("retired_cnt", Retired_Count, 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage. It sits directly downstream of the data memory and consumes the memory read word, ALU result and control bits.
- It selects and extends load data (byte/half/word, signed/unsigned), picks between memory and ALU results, and registers the write-back bundle for the register file.
- It detects misaligned loads and holds a sticky first-fault exception record until software or the control unit acknowledges it.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register-file address width.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Valid_MEM  in  1  MEM slot holds a real instruction.
- Read_Data_MEM  in  DATA_W  word from data memory.
- ALU_Result_MEM  in  DATA_W  ALU result / effective address.
- Write_Register_MEM  in  REG_ADDR_W  destination register.
- RegWrite_MEM  in  1  instruction writes the register file.
- MemtoReg_MEM  in  1  1 = load result, 0 = ALU result.
- Load_Type_MEM  in  3  load size/sign code (see package).
- Stall_WB  in  1  hold the WB register.
- Flush_WB  in  1  insert a bubble.
- Exc_Ack  in  1  one-cycle pulse that clears the pending exception.
- Write_Data_WB  out  DATA_W  data to the register file.
- Write_Register_WB  out  REG_ADDR_W  destination to the register file.
- RegWrite_WB  out  1  register-file write enable.
- Valid_WB  out  1  WB slot valid.
- Exc_Pending_WB  out  1  sticky misaligned-load flag.
- Exc_Addr_WB  out  DATA_W  address of the first misaligned load.

Behaviour:
- Reset (Reset_n = 0, async): all outputs and state go to 0.
- Latency: 1 cycle. The MEM bundle captured on rising edge N appears on the outputs after edge N.
- Update priority per edge: flush > stall > load.
  - Flush: Valid_WB = 0, RegWrite_WB = 0, data/register fields hold their old values. Flush wins over a simultaneous stall.
  - Stall: all WB outputs hold their values.
  - Otherwise: capture the new bundle. Valid_WB = Valid_MEM.
- Byte lane comes from ALU_Result_MEM[1:0]; lane 0 = bits [7:0] (little-endian).
- Load extraction:
  - LB/LBU: select the byte, then sign- or zero-extend to 32 bits.
  - LH/LHU: lane 0 selects [15:0], lane 2 selects [31:16], then extend.
  - LW: the full word.
- MemtoReg_MEM = 0: Write_Data_WB = ALU_Result_MEM, and Load_Type_MEM is ignored.
- Misaligned load: MemtoReg_MEM = 1 and Valid_MEM = 1 and either:
  - LH/LHU with addr[0] = 1, or
  - LW with addr[1:0] != 0.
- On a captured misaligned load:
  - RegWrite_WB = 0 and Write_Data_WB = 0.
  - Exc_Pending_WB is set.
  - Exc_Addr_WB captures the address only if nothing is pending (first fault wins).
- Exc_Ack clears Exc_Pending_WB. If a new misaligned load is captured in the same cycle, it sets the flag again and loads its address (the set wins).
- Exception logic is evaluated only on capture cycles, never on stall or flush cycles.
- RegWrite_WB is forced to 0 when Write_Register_MEM = 0 ($zero) or Valid_MEM = 0.
- Reserved Load_Type codes are treated as LW.
- Reset asserted mid-stall or mid-exception clears everything immediately. No capture happens on the first edge after release unless Reset_n is high at that edge.

Optional Feature:
- Macro MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output Retired_Count (32 bits), reset to 0.
  - Increments on every capture edge where Valid_MEM = 1 and the load is not misaligned.
  - Does not increment on stall or flush; wraps from FFFF_FFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mem_wb_pkg holds:
  - Load_Type codes: LW = 3'd0, LH = 1, LHU = 2, LB = 3, LBU = 4.
  - A DATA_W constant.
  - The misalign predicate as a function.
- One sub-module, load_extract (purely combinational): Read_Data, addr[1:0], Load_Type -> 32-bit extended data plus a misalign flag.

Test Plan:
- Reset:
  - Stimulus: hold Reset_n = 0 while driving arbitrary inputs.
  - Response: every output reads 0 at all times, including before the first clock edge.
- LB sign-extend:
  - Stimulus: Read_Data_MEM = 0x12F4_80AB, addr = 0x10 | 1, Load_Type = LB, MemtoReg = 1, RegWrite = 1, reg = 7.
  - Response: one cycle later Write_Data_WB = 0xFFFF_FF80, Write_Register_WB = 7, RegWrite_WB = 1.
- LHU / LW:
  - Stimulus: LHU with lane 2 on 0x8001_0000.
  - Response: Write_Data_WB = 0x0000_8001.
  - Stimulus: LW at addr 0x22.
  - Response: RegWrite_WB = 0, Exc_Pending_WB = 1, Exc_Addr_WB = 0x22.
- First-fault with ack:
  - Stimulus: misaligned loads at 0x22 then 0x33; then Exc_Ack pulsed in the same cycle as a misaligned load at 0x41.
  - Response: after the first two, Exc_Addr_WB stays 0x22. After the ack cycle, Exc_Pending_WB = 1 and Exc_Addr_WB = 0x41.
- Stall/flush:
  - Stimulus: an ALU result 0xDEAD_BEEF is captured, then Stall_WB is held for 3 cycles while inputs change.
  - Response: outputs stay 0xDEAD_BEEF throughout the stall.
  - Stimulus: Flush_WB and Stall_WB asserted together.
  - Response: Valid_WB = 0 and RegWrite_WB = 0.
- $zero and counter:
  - Stimulus: write to register 0.
  - Response: RegWrite_WB = 0.
  - Stimulus: with MEM_WB_RETIRE_CNT_EN defined, 5 valid instructions including 1 stalled cycle and 1 misaligned load.
  - Response: Retired_Count = 4.
